// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM states, default
// sizing and the single-bit adder cells used by the ripple adder stage.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int COUNT_WIDTH   = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Half adder cell: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Full adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
    return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
  endfunction

endpackage

// File: rtl/shift_add_multiplier_add_stage.sv
// Combinational WIDTH-bit ripple-carry adder built from half/full adder
// cells. Used once per multiplier bit to add the multiplicand into the
// upper half of the partial product.
module mult_add_stage
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // carry_s[i] is the carry into bit i; bit 0 has no carry-in.
  logic [WIDTH:1] carry_s;

  // Ripple the carry from the LSB half adder through the full adder chain.
  always_comb begin
    carry_s = '0;
    sum     = '0;
    {carry_s[1], sum[0]} = half_add(x[0], y[0]);
    for (int i = 1; i < WIDTH; i++) begin
      {carry_s[i+1], sum[i]} = full_add(x[i], y[i], carry_s[i]);
    end
  end

  assign carry_out = carry_s[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-add multiplier. One adder pass
// per multiplier bit; operands in and product out over valid/ready.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   count_r;
  logic [WIDTH-1:0]   m_r;
  // Partial product. The leading bit of the 2*WIDTH+1-bit formulation is
  // always zero after the shift, so only the lower 2*WIDTH bits are stored.
  logic [2*WIDTH-1:0] p_r;
  logic [2*WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0]   addend_s;
  logic [WIDTH-1:0]   sum_s;
  logic               carry_s;
  logic               accept_s;
  logic               step_s;
  logic               last_step_s;
  logic               release_s;
  logic               out_valid_r;
  logic [2*WIDTH-1:0] product_r;
  logic               ovf_r;

  // Add the multiplicand only when the current multiplier LSB is set.
  assign addend_s = p_r[0] ? m_r : '0;

  mult_add_stage #(.WIDTH(WIDTH)) u_add_stage (
    .x         (p_r[2*WIDTH-1:WIDTH]),
    .y         (addend_s),
    .sum       (sum_s),
    .carry_out (carry_s)
  );

  // Keep the adder carry and shift right by one: the multiplier bits drain
  // out of the bottom as product bits fill in from the top.
  assign p_next_s = {carry_s, sum_s, p_r[WIDTH-1:1]};

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    step_s       = 1'b0;
    last_step_s  = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s     = 1'b1;
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (count_r == LAST_COUNT) begin
          last_step_s  = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, step counter and partial-product shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      m_r     <= '0;
      p_r     <= '0;
    end else if (accept_s) begin
      count_r <= '0;
      m_r     <= a;
      p_r     <= {{WIDTH{1'b0}}, b};
    end else if (step_s) begin
      count_r <= count_r + CNT_W'(1);
      p_r     <= p_next_s;
    end
  end

  // Registered result: captured on the final step, held until transfer,
  // cleared once downstream takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      product_r   <= '0;
      ovf_r       <= 1'b0;
    end else if (last_step_s) begin
      out_valid_r <= 1'b1;
      product_r   <= p_next_s;
      ovf_r       <= |p_next_s[2*WIDTH-1:WIDTH];
    end else if (release_s) begin
      out_valid_r <= 1'b0;
      product_r   <= '0;
      ovf_r       <= 1'b0;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign product   = product_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios plus
// randomized operands, checked every cycle against a transaction model.
module tb_shift_add_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           ovf;

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return (2*W)'(x) * (2*W)'(y);
  endfunction

  // Transaction-level model: at most one operation in flight; result due
  // WIDTH+1 cycles after acceptance and held until taken.
  int             cyc = 0;
  bit             pending = 0;
  int             due = 0;
  int             acc_cyc = 0;
  int             prev_acc = 0;
  int             accepts = 0;
  int             xfers = 0;
  bit             seen_valid = 0;
  int             last_latency = 0;
  logic [2*W-1:0] exp_prod = '0;
  logic [2*W-1:0] prod_log [0:255];
  logic           ovf_log  [0:255];

  // Compare DUT outputs with the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic exp_v;
    cyc++;
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_product", product, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      pending = 0;
    end else begin
      exp_v = pending && (cyc >= due);
      chk("in_ready", in_ready, !pending);
      chk("out_valid", out_valid, exp_v);
      if (out_valid && exp_v) begin
        chk("product", product, exp_prod);
        chk("ovf", ovf, (exp_prod[2*W-1:W] != 0));
        if (!seen_valid) begin
          seen_valid   = 1;
          last_latency = cyc - acc_cyc;
        end
      end
      if (out_valid && out_ready) begin
        prod_log[xfers & 255] = product;
        ovf_log[xfers & 255]  = ovf;
        xfers++;
        pending = 0;
      end
      if (in_valid && in_ready) begin
        if (accepts > 0) chk("issue_gap_ok", (cyc - prev_acc) >= (W + 2), 1);
        pending    = 1;
        exp_prod   = ref_mul(a, b);
        due        = cyc + W + 1;
        acc_cyc    = cyc;
        prev_acc   = cyc;
        seen_valid = 0;
        accepts++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair until accepted, then scramble a/b.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    bit got;
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    n = 0;
    got = 0;
    while (!got && n < 200) begin
      got = in_ready;
      tick();
      n++;
    end
    if (!got) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_xfers(input int target, input bit rnd_ready);
    int n;
    n = 0;
    while (xfers < target && n < 300) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (xfers < target) chk("xfer_timeout", xfers, target);
    out_ready = 1'b1;
  endtask

  initial begin
    int base;
    int n;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Pin the reference model itself to hand-computed values.
    chk("model_13x11", ref_mul(8'd13, 8'd11), 143);
    chk("model_255x255", ref_mul(8'd255, 8'd255), 65025);
    chk("model_20x20", ref_mul(8'd20, 8'd20), 400);

    // Basic product and latency.
    send(8'd13, 8'd11);
    wait_xfers(1, 0);
    chk("t1_product", prod_log[0], 143);
    chk("t1_ovf", ovf_log[0], 0);
    chk("t1_latency", last_latency, W + 1);

    // Maximum operands: carry must survive every step.
    send(8'd255, 8'd255);
    wait_xfers(2, 0);
    chk("t2_product", prod_log[1], 16'hFE01);
    chk("t2_ovf", ovf_log[1], 1);

    // Zero operand followed immediately by another pair.
    send(8'd0, 8'd200);
    send(8'd15, 8'd17);
    wait_xfers(4, 0);
    chk("t3a_product", prod_log[2], 0);
    chk("t3a_ovf", ovf_log[2], 0);
    chk("t3b_product", prod_log[3], 255);
    chk("t3b_ovf", ovf_log[3], 0);

    // Downstream stall for five cycles.
    out_ready = 1'b0;
    send(8'd20, 8'd20);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t4_valid_seen", out_valid, 1);
    repeat (5) tick();
    chk("t4_no_early_xfer", xfers, 4);
    out_ready = 1'b1;
    wait_xfers(5, 0);
    chk("t4_product", prod_log[4], 400);
    chk("t4_ovf", ovf_log[4], 1);
    repeat (3) tick();
    chk("t4_single_xfer", xfers, 5);

    // in_valid held during CALC must not disturb the running operation.
    send(8'd3, 8'd5);
    in_valid = 1'b1;
    a = 8'd100;
    b = 8'd100;
    send(8'd100, 8'd100);
    wait_xfers(7, 0);
    chk("t5a_product", prod_log[5], 15);
    chk("t5b_product", prod_log[6], 10000);
    chk("t5b_ovf", ovf_log[6], 1);

    // Reset in the middle of CALC aborts without output.
    send(8'd9, 8'd9);
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    base = xfers;
    repeat (12) tick();
    chk("t6_no_output", xfers, base);
    send(8'd2, 8'd3);
    wait_xfers(base + 1, 0);
    chk("t6_product", prod_log[base & 255], 6);

    // Randomized operands with random backpressure and idle gaps.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: begin ra = '0;          rb = W'($urandom); end
        1: begin ra = {W{1'b1}};   rb = {W{1'b1}};    end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      base = xfers;
      send(ra, rb);
      wait_xfers(base + 1, 1);
      chk("rnd_product", prod_log[base & 255], ref_mul(ra, rb));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
